// File: rtl/seq101_share_arbiter_if.sv
// Serial-lane side and hit-event side of the shared 1-0-1 detector.
// The master drives lanes and accepts hits; the slave is the detector block.
interface seq101_share_arbiter_if #(
    parameter int NCHAN = 4,
    parameter int CNTW  = 8
);
    logic [NCHAN-1:0]         bit_valid;
    logic [NCHAN-1:0]         bit_data;
    logic [NCHAN-1:0]         bit_ready;
    logic                     flush;
    logic                     hit_valid;
    logic [$clog2(NCHAN)-1:0] hit_chan;
    logic                     hit_ready;
    logic [CNTW-1:0]          hit_total;

    modport master (
        output bit_valid, bit_data, flush, hit_ready,
        input  bit_ready, hit_valid, hit_chan, hit_total
    );

    modport slave (
        input  bit_valid, bit_data, flush, hit_ready,
        output bit_ready, hit_valid, hit_chan, hit_total
    );
endinterface

// File: rtl/seq101_share_arbiter.sv
// One overlapping 1-0-1 detector time-shared over NCHAN lanes by a round-robin arbiter.
// Hit visible one edge after the completing bit; no lane is granted while a hit waits unaccepted.
module seq101_share_arbiter #(
    parameter int NCHAN = 4,
    parameter int CNTW  = 8
) (
    input  logic                  clock,
    input  logic                  reset_L,
    seq101_share_arbiter_if.slave io
);
    localparam int              CW     = $clog2(NCHAN);
    localparam logic [CW:0]     NCH_W  = (CW+1)'(NCHAN);
    localparam logic [CW-1:0]   LAST   = CW'(NCHAN - 1);

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        SAW1    = 2'd1,
        SAW10   = 2'd2
    } det_state_t;

    det_state_t        st_q [NCHAN];
    det_state_t        det_nxt;
    logic [CW-1:0]     ptr_q;
    logic [CW-1:0]     ptr_nxt;
    logic [CW-1:0]     gnt_idx;
    logic [CW-1:0]     hit_chan_q;
    logic [CW:0]       scan_sum;
    logic [CW-1:0]     scan_idx;
    logic              gnt_vld;
    logic              can_grant;
    logic              hit_valid_q;
    logic              det_bit;
    logic              det_hit;
    logic              drain;
    logic [CNTW-1:0]   hit_total_q;
    logic [NCHAN-1:0]  ready;

    // Reset and flush both force bit_ready low so no handshake can complete.
    always_comb begin
        can_grant = reset_L && !io.flush && (!hit_valid_q || io.hit_ready);
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NCHAN; i++) begin
            scan_sum = {1'b0, ptr_q} + (CW+1)'(i);
            if (scan_sum >= NCH_W) begin
                scan_sum = scan_sum - NCH_W;
            end
            scan_idx = scan_sum[CW-1:0];
            if (!gnt_vld && io.bit_valid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        gnt_vld = gnt_vld && can_grant;
        ready   = gnt_vld ? (NCHAN'(1) << gnt_idx) : '0;
        ptr_nxt = (gnt_idx == LAST) ? '0 : gnt_idx + CW'(1);
    end

    always_comb begin
        det_bit = io.bit_data[gnt_idx];
        det_hit = 1'b0;
        det_nxt = NOTHING;
        case (st_q[gnt_idx])
            NOTHING: det_nxt = det_bit ? SAW1 : NOTHING;
            SAW1:    det_nxt = det_bit ? SAW1 : SAW10;
            SAW10: begin
                det_nxt = det_bit ? SAW1 : NOTHING;
                det_hit = det_bit;
            end
            default: det_nxt = NOTHING;
        endcase
    end

    assign drain = hit_valid_q && io.hit_ready;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NCHAN; i++) st_q[i] <= NOTHING;
            ptr_q       <= '0;
            hit_valid_q <= 1'b0;
            hit_chan_q  <= '0;
            hit_total_q <= '0;
        end else if (io.flush) begin
            for (int i = 0; i < NCHAN; i++) st_q[i] <= NOTHING;
            ptr_q       <= '0;
            hit_valid_q <= 1'b0;
            hit_chan_q  <= '0;
            hit_total_q <= '0;
        end else begin
            if (gnt_vld) begin
                st_q[gnt_idx] <= det_nxt;
                ptr_q         <= ptr_nxt;
            end
            // A new hit refills the slot even when the old one drains this edge.
            if (gnt_vld && det_hit) begin
                hit_valid_q <= 1'b1;
                hit_chan_q  <= gnt_idx;
            end else if (drain) begin
                hit_valid_q <= 1'b0;
            end
            if (drain && (hit_total_q != '1)) begin
                hit_total_q <= hit_total_q + CNTW'(1);
            end
        end
    end

    assign io.bit_ready = ready;
    assign io.hit_valid = hit_valid_q;
    assign io.hit_chan  = hit_chan_q;
    assign io.hit_total = hit_total_q;
endmodule

// File: doc/seq101_share_arbiter.md
# seq101_share_arbiter

Time-multiplexes one overlapping "1-0-1" serial pattern detector across NCHAN independent serial input channels. A round-robin arbiter accepts at most one bit per cycle through per-channel valid/ready handshakes. The block keeps each channel's detector state in a small state table and emits a tagged hit event whenever a channel completes the pattern. It sits between the serial front-end lanes and the event-logging logic, replacing NCHAN copies of the single-stream detector.

## Interface
- NCHAN, 4, number of serial input channels (2..8)
- CNTW, 8, width of the saturating hit counter
- clock  in  1  single system clock, rising-edge
- reset_L  in  1  asynchronous, active-low reset
- bit_valid  in  NCHAN  per-channel "bit available"
- bit_data  in  NCHAN  per-channel serial bit, meaningful when bit_valid[i]=1
- bit_ready  out  NCHAN  per-channel accept; one-hot or zero; combinational
- flush  in  1  synchronous clear of channel states, hit output and counter
- hit_valid  out  1  hit event pending
- hit_chan  out  $clog2(NCHAN)  channel that produced the pending hit
- hit_ready  in  1  consumer accepts the hit event
- hit_total  out  CNTW  saturating count of hit events accepted by the consumer

## Operation
- Per-channel state is 2 bits: NOTHING, SAW1, SAW10.
- Transitions on a consumed bit a:
  - NOTHING: a=1 goes to SAW1; a=0 stays NOTHING.
  - SAW1: a=1 stays SAW1; a=0 goes to SAW10.
  - SAW10: a=1 goes to SAW1 and signals a hit; a=0 goes to NOTHING.
- Detection overlaps: 1,0,1,0,1 on one channel produces 2 hits.
- Channel states are fully independent. Interleaving bits from other channels never affects a channel's sequence.
- A grant may be issued only when the output slot is free: can_grant = !hit_valid || hit_ready.
- Arbiter: round-robin pointer ptr. Among channels with bit_valid=1, grant the first found searching ptr, ptr+1, … wrapping mod NCHAN.
  - After a grant to channel g, ptr becomes (g+1) mod NCHAN.
  - ptr does not change when there is no grant.
- Grant effects:
  - bit_ready[g]=1 and all other bits are 0.
  - The handshake completes on that clock edge: the bit is consumed and the channel state is updated.
- Hit from a granted bit: on the same edge, hit_valid becomes 1 and hit_chan becomes g.
- Slot handling:
  - If the slot drains (hit_valid && hit_ready) and the granted bit makes no hit, hit_valid becomes 0.
  - If the slot drains and the granted bit makes a hit, the slot is refilled in the same cycle.
- hit_total increments by 1 on each edge where hit_valid && hit_ready. It saturates at 2^CNTW-1.
- flush=1 has priority over all other activity:
  - bit_ready is all 0.
  - On the edge: all states become NOTHING, hit_valid=0, hit_chan=0, hit_total=0, ptr=0.
  - A pending hit is discarded and not counted.
- bit_data of non-granted channels is ignored. bit_valid may drop without being granted; the bit is then lost with no error.

## Timing
- Reset values (asynchronous, while reset_L=0):
  - hit_valid=0, hit_chan=0, hit_total=0.
  - ptr=0, all channel states NOTHING.
  - bit_ready=0 is forced combinationally.
- bit_ready depends combinationally on bit_valid, ptr, hit_valid, hit_ready and flush. There is no combinational path from bit_data.
- Latency: the bit completing a pattern is consumed at edge N. hit_valid is visible after edge N.
- Throughput: one bit per cycle aggregate, with no bubbles while hit_ready=1.
- Backpressure: with hit_valid=1 and hit_ready=0, bit_ready stays all 0.
  - hit_valid and hit_chan hold stable until accepted.
  - No channel state changes.
- hit_total reflects an acceptance one cycle after the accepting edge.
- Reset deasserting mid-stream restarts all channels at NOTHING. Partial patterns are lost.

## Test plan
- Single channel, NCHAN=4: ch0 presents 1,0,1,0,1 continuously, others idle, hit_ready=1.
  - bit_ready[0] is high for 5 cycles.
  - hit_valid pulses after the 3rd and 5th bits, both with hit_chan=0.
  - hit_total=2.
- Fairness: all 4 channels valid every cycle.
  - Grants run 0,1,2,3,0,1… with no channel granted twice before the others.
  - Each channel fed 1,0,1 hits in grant order, giving hit_chan 0,1,2,3 and hit_total=4.
- Interleave independence: ch1 sends 1,0 then ch2 sends 0,0,0, then ch1 sends 1.
  - Exactly one hit with hit_chan=1.
  - ch2 produces no hit.
- Backpressure: hit pending on ch3 with hit_ready=0 for 5 cycles while ch0 and ch1 are valid.
  - bit_ready=0 and hit_chan=3 hold for those 5 cycles.
  - After hit_ready=1, grants resume starting at ch0 (ptr=0 after the ch3 grant).
- Saturation and flush, CNTW=2: produce 5 accepted hits.
  - hit_total stops at 3.
  - Assert flush with a hit pending: after the edge hit_valid=0 and hit_total=0.
  - A ch0 partial 1,0 is forgotten: the next 1 produces no hit.
- Async reset mid-pattern: pull reset_L low between edges.
  - Outputs reach 0 immediately, without waiting for a clock edge.
  - After release, the sequence 0,1 yields no hit.
